// File: rtl/score_digit_renderer.sv
// Score overlay: per-frame BCD conversion of the score plus a two-stage sprite lookup pipeline.
// Optional: define SCORE_LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module score_digit_renderer #(
  parameter int X0     = 300,
  parameter int Y0     = 20,
  parameter int WIDTH  = 11,
  parameter int HEIGHT = 16,
  parameter int GAP    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_col,
  input  logic       frame_start,
  input  logic [6:0] score,
  output logic [9:0] sprite_row,
  output logic [9:0] sprite_col,
  output logic [3:0] sprite_sel,
  input  logic [2:0] sprite_rgb,
  output logic [2:0] rgb,
  output logic       busy
);

  localparam logic [9:0] TENS_X0 = 10'(X0);
  localparam logic [9:0] TENS_X1 = 10'(X0 + WIDTH);
  localparam logic [9:0] ONES_X0 = 10'(X0 + WIDTH + GAP);
  localparam logic [9:0] ONES_X1 = 10'(X0 + 2*WIDTH + GAP);
  localparam logic [9:0] BOX_Y0  = 10'(Y0);
  localparam logic [9:0] BOX_Y1  = 10'(Y0 + HEIGHT);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t     state, state_nxt;
  logic [6:0] w, w_nxt;
  logic [3:0] t, t_nxt;
  logic [3:0] shown_tens, shown_ones;
  logic       commit;

  // Repeated subtraction: at most 9 iterations since w is clamped to 99.
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    t_nxt     = t;
    commit    = 1'b0;
    case (state)
      IDLE: ;
      CONVERT: begin
        if (w >= 7'd10) begin
          w_nxt = w - 7'd10;
          t_nxt = t + 4'd1;
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new frame always restarts from the live score and abandons any pending commit.
    if (frame_start) begin
      state_nxt = CONVERT;
      w_nxt     = (score > 7'd99) ? 7'd99 : score;
      t_nxt     = 4'd0;
      commit    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      w          <= '0;
      t          <= '0;
      shown_tens <= '0;
      shown_ones <= '0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      t     <= t_nxt;
      if (commit) begin
        shown_tens <= t;
        shown_ones <= w[3:0];
      end
    end
  end

  assign busy = (state == CONVERT);

  logic       in_rows, in_tens, in_ones, tens_vis, hit_d, hit;
  logic [9:0] row_d, col_d;
  logic [3:0] sel_d;

  assign in_rows = (pixel_row >= BOX_Y0) && (pixel_row < BOX_Y1);
  assign in_tens = in_rows && (pixel_col >= TENS_X0) && (pixel_col < TENS_X1);
  assign in_ones = in_rows && (pixel_col >= ONES_X0) && (pixel_col < ONES_X1);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  assign tens_vis = in_tens && (shown_tens != 4'd0);
`else
  assign tens_vis = in_tens;
`endif

  always_comb begin
    hit_d = 1'b0;
    row_d = '0;
    col_d = '0;
    sel_d = '0;
    if (tens_vis) begin
      hit_d = 1'b1;
      row_d = pixel_row - BOX_Y0;
      col_d = pixel_col - TENS_X0;
      sel_d = shown_tens;
    end else if (in_ones) begin
      hit_d = 1'b1;
      row_d = pixel_row - BOX_Y0;
      col_d = pixel_col - ONES_X0;
      sel_d = shown_ones;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_row <= '0;
      sprite_col <= '0;
      sprite_sel <= '0;
      hit        <= 1'b0;
      rgb        <= '0;
    end else begin
      sprite_row <= row_d;
      sprite_col <= col_d;
      sprite_sel <= sel_d;
      hit        <= hit_d;
      rgb        <= hit ? sprite_rgb : 3'b000;
    end
  end

endmodule
